regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (RegWrite/RD/write_data) between NUM_REQ writeback requesters, e.g. the single-cycle ALU path and a multi-cycle load/multiply unit. Uses round-robin arbitration with valid/ready handshakes and a registered output stage that drives the register file directly. Writes to x0 are accepted and discarded. Also keeps a saturating contention counter for performance checks.

Parameters:
NUM_REQ, 2, number of writeback requesters (2..8)
CNT_W, 16, width of the contention counter

Ports:
clock  input  1  rising-edge clock shared with the register file
reset_n  input  1  synchronous, active-low reset
req_valid  input  NUM_REQ  requester i has a write pending
req_rd  input  5*NUM_REQ  destination register; slice i = [5*i+4:5*i]
req_data  input  32*NUM_REQ  write value; slice i = [32*i+31:32*i]
req_ready  output  NUM_REQ  one-hot grant; transfer when valid[i]&ready[i]
wb_stall  input  1  blocks all grants this cycle
RegWrite  output  1  register-file write enable (registered)
RD  output  5  register-file destination (registered)
write_data  output  32  register-file write value (registered)
grant_id  output  3  index of the requester whose write is on RD/write_data
conflict_cnt  output  CNT_W  saturating count of cycles with >=2 valid requests and no stall

Behaviour:
- Reset (reset_n low at a rising edge):
  - RegWrite=0, RD=0, write_data=0, grant_id=0, conflict_cnt=0.
  - Round-robin pointer last_grant=NUM_REQ-1, so requester 0 has first priority.
  - req_ready is forced to all-0 whenever reset_n is low (combinational), so no transfer occurs in a reset cycle.
- Arbitration (combinational):
  - If wb_stall=0, grant the first valid requester scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - req_ready is one-hot on that index, or all-0 if no request is valid or wb_stall=1.
  - req_ready never asserts for a requester whose valid is low.
- Requester rule: once valid is high, rd and data are held stable until ready; the bench flags any violation.
- Transfer at edge with granted index g:
  - last_grant<=g, grant_id<=g, RD<=req_rd[g], write_data<=req_data[g].
  - RegWrite<=1 if req_rd[g]!=0, else RegWrite<=0 (x0 write dropped, but the handshake still completes and the pointer still advances).
- No transfer: RegWrite<=0; RD, write_data, grant_id and last_grant hold.
- Latency: an accept at edge N gives RegWrite=1 during cycle N..N+1; the register file commits at edge N+1. Sustained throughput is one write per cycle.
- Fairness: with wb_stall=0, a continuously valid requester is granted within NUM_REQ cycles.
- Simultaneous requests:
  - Exactly one is granted; the others see ready=0 and keep valid.
  - conflict_cnt increments by 1 per such cycle and saturates at all-ones (no wrap).
- wb_stall=1: no grant, conflict_cnt does not increment, RegWrite drops to 0 next cycle; pending requests are preserved by their owners.
- Reset mid-operation: an in-flight registered write (RegWrite=1) is cancelled at the reset edge, so the register file sees RegWrite=0 on the following edge.

Optional Feature:
Macro REGFILE_WB_FWD_EN.
- Defined: adds the following ports:
  - fwd_rs1 input 5, fwd_rs2 input 5
  - fwd_hit1 output 1, fwd_hit2 output 1, fwd_data output 32
- fwd_hitK = RegWrite & (RD==fwd_rsK) & (fwd_rsK!=0), combinational from the output registers.
- fwd_data = write_data. This lets readers bypass the write that the register file commits at the next edge.
- Not defined: these ports do not exist and there is no forwarding logic; the rest of the behaviour is identical.

Test Plan:
1. Reset: hold reset_n=0 for 2 cycles with req_valid=2'b11 -> req_ready=0, RegWrite=0, RD=0, conflict_cnt=0; release -> first grant goes to req 0.
2. Single write: req0 valid rd=5 data=0xDEADBEEF for 1 cycle -> next cycle RegWrite=1, RD=5, write_data=0xDEADBEEF, grant_id=0; the cycle after, RegWrite=0.
3. Contention: both requesters valid for 4 cycles (rd 3/7) -> grants 0,1,0,1; conflict_cnt=4; RegWrite high on 4 consecutive cycles.
4. x0 drop: req1 rd=0 data=0x1234 -> req_ready[1]=1, next cycle RegWrite=0; pointer advances, so the next contended grant goes to req0.
5. Stall: both valid with wb_stall=1 for 3 cycles -> req_ready=0, RegWrite=0, conflict_cnt unchanged; release -> grant resumes from the saved pointer.
6. REGFILE_WB_FWD_EN: after a write rd=9 is accepted, drive fwd_rs1=9, fwd_rs2=0 -> fwd_hit1=1, fwd_hit2=0, fwd_data equals the written value.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between NUM_REQ writeback requesters.
// Round-robin arbitration with valid/ready handshakes feeds a registered output stage
// that drives the register file directly. Writes to x0 complete the handshake but
// are not issued. A saturating counter records contended, unstalled cycles.
//
// Optional feature: define REGFILE_WB_FWD_EN to add bypass ports that expose the
// registered write before the register file commits it.
//
// Ports:
//   clock        rising-edge clock shared with the register file
//   reset_n      synchronous active-low reset
//   req_valid    per-requester write pending
//   req_rd       per-requester destination, slice i = [5*i+4:5*i]
//   req_data     per-requester write value, slice i = [32*i+31:32*i]
//   req_ready    one-hot grant; transfer when valid[i] & ready[i]
//   wb_stall     blocks all grants this cycle
//   RegWrite     register-file write enable (registered)
//   RD           register-file destination (registered)
//   write_data   register-file write value (registered)
//   grant_id     requester whose write is on RD/write_data
//   conflict_cnt saturating count of cycles with >=2 valid requests and no stall
//   fwd_rs1/2, fwd_hit1/2, fwd_data  (REGFILE_WB_FWD_EN only) bypass compare/data
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [5*NUM_REQ-1:0]  req_rd,
  input  logic [32*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  wb_stall,
  output logic                  RegWrite,
  output logic [4:0]            RD,
  output logic [31:0]           write_data,
  output logic [2:0]            grant_id,
  output logic [CNT_W-1:0]      conflict_cnt
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [4:0]            fwd_rs1,
  input  logic [4:0]            fwd_rs2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [31:0]           fwd_data
`endif
);

  logic [2:0]  last_grant_q;

  // Requester fields padded to 8 entries so 3-bit indices are always in range.
  logic [7:0]  valid_ext;
  logic [4:0]  rd_arr   [8];
  logic [31:0] data_arr [8];

  always_comb begin
    valid_ext = 8'(req_valid);
    for (int unsigned i = 0; i < 8; i++) begin
      rd_arr[i]   = '0;
      data_arr[i] = '0;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      rd_arr[i]   = req_rd[5*i +: 5];
      data_arr[i] = req_data[32*i +: 32];
    end
  end

  // Round-robin scan starting just after the last granted requester.
  logic       gnt_found;
  logic [2:0] gnt_idx;
  logic [3:0] cand;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = last_grant_q;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = {1'b0, last_grant_q} + 4'(off);
      if (cand >= 4'(NUM_REQ)) begin
        cand = cand - 4'(NUM_REQ);
      end
      if (!gnt_found && valid_ext[cand[2:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[2:0];
      end
    end
  end

  // A grant only exists out of reset and without stall; it is also the transfer.
  logic grant_en;
  assign grant_en = reset_n & ~wb_stall & gnt_found;

  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = grant_en && (3'(i) == gnt_idx);
    end
  end

  logic [3:0] num_valid;
  logic       conflict;

  always_comb begin
    num_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      num_valid = num_valid + 4'(req_valid[i]);
    end
    conflict = (num_valid >= 4'd2) && !wb_stall;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      RegWrite     <= 1'b0;
      RD           <= '0;
      write_data   <= '0;
      grant_id     <= '0;
      conflict_cnt <= '0;
      last_grant_q <= 3'(NUM_REQ - 1);
    end else begin
      if (grant_en) begin
        last_grant_q <= gnt_idx;
        grant_id     <= gnt_idx;
        RD           <= rd_arr[gnt_idx];
        write_data   <= data_arr[gnt_idx];
        // x0 writes finish the handshake but never reach the register file.
        RegWrite     <= (rd_arr[gnt_idx] != 5'd0);
      end else begin
        RegWrite     <= 1'b0;
      end
      if (conflict && !(&conflict_cnt)) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit1 = RegWrite && (RD == fwd_rs1) && (fwd_rs1 != 5'd0);
  assign fwd_hit2 = RegWrite && (RD == fwd_rs2) && (fwd_rs2 != 5'd0);
  assign fwd_data = write_data;
`endif

endmodule
